// File: rtl/fft_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_arbiter
//  Purpose  : Shares one fft_top instance between two sample requesters.
//             Input side: frame-granular round-robin arbitration; a granted
//             requester owns the FFT input for exactly N samples.
//             Output side: an owner-tag queue steers each transformed frame
//             back to the requester that submitted it, in submission order.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             req_din/valid/ready - two sample sources, {re, im} per sample
//             rsp_dout/valid/ready - two result sinks sharing one data bus
//             fft_din/wr_en/in_valid/in_full - fft_top input FIFO
//             fft_dout/empty/rd_en - fft_top output FIFO (first-word-fall-through)
//             busy              - input frame in progress or frames in flight
//  Revision : 1.0 - initial release
// ============================================================================
module fft_frame_arbiter #(
    parameter int N          = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0][2*DATA_WIDTH-1:0]   req_din,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    output logic [2*DATA_WIDTH-1:0]        rsp_dout,
    output logic [1:0]                     rsp_valid,
    input  logic [1:0]                     rsp_ready,
    output logic [2*DATA_WIDTH-1:0]        fft_din,
    output logic                           fft_wr_en,
    output logic                           fft_in_valid,
    input  logic                           fft_in_full,
    input  logic [2*DATA_WIDTH-1:0]        fft_dout,
    input  logic                           fft_empty,
    output logic                           fft_rd_en,
    output logic                           busy
);

    localparam int c_CNT_W = $clog2(N);
    localparam int c_PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int c_OCC_W = $clog2(TAG_DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(N - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(TAG_DEPTH - 1);
    localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(TAG_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_grant;
    logic                   r_last_grant;
    logic [c_CNT_W-1:0]     r_in_cnt;
    logic [c_CNT_W-1:0]     r_out_cnt;

    // Owner-tag queue: one bit per frame in flight, circular buffer.
    logic [TAG_DEPTH-1:0]   r_tag_mem;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_OCC_W-1:0]     r_occ;

    logic                   w_tag_empty;
    logic                   w_tag_full;
    logic                   w_owner;
    logic                   w_pick;
    logic                   w_grant_go;
    logic                   w_in_hs;
    logic                   w_out_vld;
    logic                   w_tag_pop;

    assign w_tag_empty = (r_occ == '0);
    assign w_tag_full  = (r_occ == c_OCC_FULL);
    assign w_owner     = r_tag_mem[r_rd_ptr];

    // On a tie the requester that did not win last time gets the frame;
    // otherwise whichever single requester is valid.
    assign w_pick = (&req_valid) ? ~r_last_grant : (req_valid[1] & ~req_valid[0]);

    // ------------------------------------------------------------------
    // Input FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_go  = 1'b0;
        w_in_hs     = 1'b0;
        req_ready   = 2'b00;
        case (r_state)
            S_IDLE: begin
                // The grant is registered; the first sample is taken next cycle.
                if ((|req_valid) && !w_tag_full) begin
                    w_grant_go  = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                req_ready[r_grant] = !fft_in_full;
                w_in_hs            = req_valid[r_grant] & !fft_in_full;
                if (w_in_hs && (r_in_cnt == c_CNT_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign fft_wr_en    = w_in_hs;
    assign fft_in_valid = w_in_hs;
    assign fft_din      = req_din[r_grant];

    // ------------------------------------------------------------------
    // Output steering
    // ------------------------------------------------------------------
    // Output data with no frame tag outstanding is never read or forwarded.
    assign w_out_vld = !w_tag_empty & !fft_empty;

    always_comb begin
        rsp_valid          = 2'b00;
        rsp_valid[w_owner] = w_out_vld;
    end

    assign fft_rd_en = w_out_vld & rsp_ready[w_owner];
    assign w_tag_pop = fft_rd_en & (r_out_cnt == c_CNT_LAST);
    assign rsp_dout  = fft_dout;
    assign busy      = (r_state == S_STREAM) | !w_tag_empty;

    // ------------------------------------------------------------------
    // Grant, counters and tag queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_tag_mem    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
        end else begin
            if (w_grant_go) begin
                r_grant             <= w_pick;
                r_last_grant        <= w_pick;
                r_in_cnt            <= '0;
                r_tag_mem[r_wr_ptr] <= w_pick;
                r_wr_ptr            <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end else if (w_in_hs) begin
                r_in_cnt <= r_in_cnt + 1'b1;
            end

            if (w_tag_pop) begin
                r_out_cnt <= '0;
                r_rd_ptr  <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end else if (fft_rd_en) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end

            // Push and pop in the same cycle leave occupancy unchanged; the
            // full check above already used the pre-update value.
            case ({w_grant_go, w_tag_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_frame_arbiter
//  Purpose  : Self-checking bench for fft_frame_arbiter. The fft_top is
//             stood in for by a pass-through queue; every accepted request
//             sample is expected back, in order, on its own requester's sink.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_arbiter;

    localparam int N  = 32;
    localparam int DW = 32;
    localparam int TD = 4;
    localparam int W  = 2 * DW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0][W-1:0]    req_din = '0;
    logic [1:0]           req_valid = '0;
    logic [1:0]           req_ready;
    logic [W-1:0]         rsp_dout;
    logic [1:0]           rsp_valid;
    logic [1:0]           rsp_ready = '0;
    logic [W-1:0]         fft_din;
    logic                 fft_wr_en;
    logic                 fft_in_valid;
    logic                 fft_in_full = 1'b0;
    logic [W-1:0]         fft_dout = '0;
    logic                 fft_empty = 1'b1;
    logic                 fft_rd_en;
    logic                 busy;

    fft_frame_arbiter #(.N(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .req_din(req_din), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_dout(rsp_dout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .fft_din(fft_din), .fft_wr_en(fft_wr_en), .fft_in_valid(fft_in_valid),
        .fft_in_full(fft_in_full), .fft_dout(fft_dout), .fft_empty(fft_empty),
        .fft_rd_en(fft_rd_en), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // stimulus knobs
    int vpct[2] = '{0, 0};
    int rdy_pct[2] = '{0, 0};
    int full_pct = 0;
    int stall_pct = 0;
    bit full_force = 0;
    bit stall_force = 0;
    bit stop_req = 0;
    bit rst_drv = 1;

    // model state
    int seq[2] = '{1, 1};
    int acc[2] = '{0, 0};
    int rsp_total[2] = '{0, 0};
    int wr_total = 0;
    int rd_total = 0;
    logic [W-1:0] fq[$];
    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];
    int owners[$];
    int frame_pos = 0;
    int cur_owner = 0;
    int last_end_cyc = 0;
    bit have_prev = 0;
    bit gap_chk_en = 0;

    // effects of the upcoming clock edge, committed at the next negedge
    bit p_rst = 1;
    logic [1:0] p_hs = '0;
    bit p_wr = 0;
    bit p_rd = 0;
    logic [W-1:0] p_wr_data = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester id in the top bit makes every sample traceable to its source.
    function automatic logic [W-1:0] mk(input int i, input int s);
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        re = {i[0], 31'(s)};
        im = 32'(s * 3 + i) ^ 32'h5A5A_0000;
        return {re, im};
    endfunction

    task automatic cycle();
        logic [1:0] hs;
        int owner;
        bit stall;
        @(negedge clk);
        cyc++;
        if (p_rst) begin
            fq.delete();
            exp0.delete();
            exp1.delete();
            frame_pos = 0;
            have_prev = 0;
        end else begin
            if (p_rd && fq.size() > 0) void'(fq.pop_front());
            if (p_wr) fq.push_back(p_wr_data);
        end
        for (int i = 0; i < 2; i++) if (p_hs[i]) seq[i]++;

        rst = rst_drv;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = int'($urandom_range(99)) < vpct[i];
            req_din[i]   = mk(i, seq[i]);
            rsp_ready[i] = int'($urandom_range(99)) < rdy_pct[i];
        end
        fft_in_full = full_force | (int'($urandom_range(99)) < full_pct);
        stall       = stall_force | (int'($urandom_range(99)) < stall_pct);
        fft_empty   = (fq.size() == 0) | stall;
        fft_dout    = (fq.size() > 0) ? fq[0] : '0;
        #1;

        p_rst = rst;
        if (rst) begin
            p_hs = '0;
            p_wr = 0;
            p_rd = 0;
        end else begin
            hs = req_valid & req_ready;
            p_hs = hs;
            check("in_valid_eq_wr", W'(fft_in_valid), W'(fft_wr_en));
            check("wr_eq_accept", W'(fft_wr_en), W'(|hs));
            check("accept_onehot", W'(hs == 2'b11), '0);
            check("rd_while_empty", W'(fft_rd_en & fft_empty), '0);
            if (hs[0]) begin exp0.push_back(req_din[0]); acc[0]++; end
            if (hs[1]) begin exp1.push_back(req_din[1]); acc[1]++; end
            if (fft_wr_en) begin
                owner = fft_din[W-1] ? 1 : 0;
                check("fft_din", fft_din, req_din[owner]);
                if (frame_pos == 0) begin
                    owners.push_back(owner);
                    cur_owner = owner;
                    if (gap_chk_en && have_prev) check("frame_gap", W'(cyc - last_end_cyc), W'(2));
                end else begin
                    check("frame_owner", W'(owner), W'(cur_owner));
                end
                frame_pos++;
                if (frame_pos == N) begin
                    frame_pos = 0;
                    last_end_cyc = cyc;
                    have_prev = 1;
                    if (stop_req) begin
                        vpct = '{0, 0};
                        stop_req = 0;
                    end
                end
                wr_total++;
            end
            p_wr = fft_wr_en;
            p_wr_data = fft_din;
            p_rd = fft_rd_en;
            if (fft_rd_en) rd_total++;
        end
    endtask

    // Output monitor: pops the per-sink expectation whenever a result is taken.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("rsp_onehot", W'(rsp_valid == 2'b11), '0);
                if (rsp_valid[0] && rsp_ready[0]) begin
                    if (exp0.size() == 0) check("rsp0_unexpected", W'(rsp_valid[0]), '0);
                    else check("rsp0_data", rsp_dout, exp0.pop_front());
                    rsp_total[0]++;
                end
                if (rsp_valid[1] && rsp_ready[1]) begin
                    if (exp1.size() == 0) check("rsp1_unexpected", W'(rsp_valid[1]), '0);
                    else check("rsp1_data", rsp_dout, exp1.pop_front());
                    rsp_total[1]++;
                end
            end
        end
    end

    task automatic do_reset();
        vpct = '{0, 0};
        rst_drv = 1;
        cycle();
        cycle();
        rst_drv = 0;
    endtask

    task automatic drain();
        int n = 0;
        rdy_pct = '{100, 100};
        full_pct = 0; full_force = 0;
        stall_pct = 0; stall_force = 0;
        while ((stop_req || busy || exp0.size() != 0 || exp1.size() != 0) && n < 4000) begin
            cycle();
            n++;
        end
        check("drain_busy", W'(busy), '0);
        check("drain_exp_empty", W'(exp0.size() + exp1.size()), '0);
    endtask

    initial begin
        int b0, b1, wb, rb, n;

        // ---- reset state ----
        do_reset();
        cycle();
        check("rst_req_ready", W'(req_ready), '0);
        check("rst_rsp_valid", W'(rsp_valid), '0);
        check("rst_wr_en", W'(fft_wr_en), '0);
        check("rst_rd_en", W'(fft_rd_en), '0);
        check("rst_busy", W'(busy), '0);

        // ---- single frame from requester 0 ----
        b0 = acc[0]; wb = wr_total; rb = rsp_total[0]; n = rsp_total[1];
        vpct = '{100, 0}; rdy_pct = '{100, 100};
        cycle();
        check("grant_cycle_ready", W'(req_ready), '0);
        cycle();
        check("stream_ready", W'(req_ready), W'(2'b01));
        while (acc[0] - b0 < N && cyc < 1000) cycle();
        vpct = '{0, 0};
        check("single_wr_count", W'(wr_total - wb), W'(N));
        drain();
        check("single_rsp0", W'(rsp_total[0] - rb), W'(N));
        check("single_rsp1", W'(rsp_total[1] - n), '0);

        // ---- tie arbitration, 4 frames ----
        do_reset();
        owners.delete();
        wb = wr_total; b0 = rsp_total[0]; b1 = rsp_total[1];
        vpct = '{100, 100}; rdy_pct = '{100, 100};
        gap_chk_en = 1;
        n = 0;
        while (wr_total - wb < 4 * N && n < 400) begin cycle(); n++; end
        vpct = '{0, 0};
        gap_chk_en = 0;
        check("tie_frames", W'(owners.size()), W'(4));
        for (int k = 0; k < 4; k++) if (k < owners.size()) check("tie_order", W'(owners[k]), W'(k % 2));
        drain();
        check("tie_rsp0", W'(rsp_total[0] - b0), W'(2 * N));
        check("tie_rsp1", W'(rsp_total[1] - b1), W'(2 * N));

        // ---- input back-pressure at in_cnt=10 ----
        do_reset();
        b0 = acc[0]; wb = wr_total;
        vpct = '{100, 0};
        n = 0;
        while (acc[0] - b0 < 10 && n < 100) begin cycle(); n++; end
        full_force = 1;
        repeat (5) begin
            cycle();
            check("bp_ready", W'(req_ready), '0);
            check("bp_wr_en", W'(fft_wr_en), '0);
        end
        full_force = 0;
        n = 0;
        while (acc[0] - b0 < N && n < 100) begin cycle(); n++; end
        vpct = '{0, 0};
        check("bp_wr_count", W'(wr_total - wb), W'(N));
        drain();

        // ---- tag queue full ----
        do_reset();
        wb = wr_total;
        stall_force = 1;
        vpct = '{100, 100}; rdy_pct = '{100, 100};
        repeat (250) cycle();
        check("tagfull_wr_count", W'(wr_total - wb), W'(TD * N));
        check("tagfull_no_ready", W'(req_ready), '0);
        check("tagfull_busy", W'(busy), W'(1));
        rb = rd_total;
        stall_force = 0;
        n = 0;
        while (rd_total - rb < N && n < 200) begin cycle(); n++; end
        stall_force = 1;
        n = 0;
        while (req_ready == 2'b00 && n < 10) begin cycle(); n++; end
        check("regrant_within_2", W'(n <= 2), W'(1));
        stop_req = 1;
        drain();

        // ---- sink 0 stall with frames queued for both sinks ----
        do_reset();
        b0 = acc[0]; b1 = acc[1];
        rdy_pct = '{0, 100};
        vpct = '{100, 0};
        n = 0;
        while (acc[0] - b0 < N && n < 100) begin cycle(); n++; end
        vpct = '{0, 100};
        n = 0;
        while (acc[1] - b1 < N && n < 100) begin cycle(); n++; end
        vpct = '{0, 0};
        repeat (20) begin
            cycle();
            check("stall_rd_en", W'(fft_rd_en), '0);
            check("stall_rsp_valid", W'(rsp_valid), W'(2'b01));
        end
        drain();

        // ---- reset in the middle of a frame ----
        do_reset();
        b0 = acc[0];
        vpct = '{100, 0}; rdy_pct = '{100, 100};
        n = 0;
        while (acc[0] - b0 < 17 && n < 100) begin cycle(); n++; end
        rst_drv = 1;
        cycle();
        rst_drv = 0;
        vpct = '{100, 100};
        owners.delete();
        cycle();
        check("midrst_busy", W'(busy), '0);
        check("midrst_ready", W'(req_ready), '0);
        n = 0;
        while (owners.size() == 0 && n < 10) begin cycle(); n++; end
        check("midrst_first_owner", W'(owners.size() > 0 ? owners[0] : 9), '0);
        stop_req = 1;
        drain();

        // ---- randomized traffic ----
        do_reset();
        vpct = '{60, 70};
        rdy_pct = '{70, 50};
        full_pct = 15;
        stall_pct = 20;
        repeat (3000) cycle();
        stop_req = 1;
        drain();
        check("random_rsp_total", W'(rsp_total[0] + rsp_total[1] >= 0 ? exp0.size() : 1), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
